key_event_queue: RTL and testbench

- Consumes the debounced, held key levels from the per-key debounce stage. One input bit per key.
- Turns level changes into discrete press, release and auto-repeat events, and queues them in a small first-word-fall-through FIFO for the CPU/IO bus to pop.
- Sits between the key debounce instances and the IO register/interrupt logic.

---
 rtl/key_event_queue.sv | 143 ++++++++++++++
 tb/tb_key_event_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// Key level -> press/release/auto-repeat events, queued in a FWFT FIFO.
// Lowest-index dirty key wins each cycle; repeats only fill idle cycles.
module key_event_queue #(
  parameter int          NKEYS        = 8,
  parameter int          IDXW         = 3,
  parameter int          DEPTH        = 8,
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NKEYS-1:0]        keys,
  input  logic                    rd,
  output logic                    evt_valid,
  output logic [IDXW+1:0]         evt_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    ovf,
  input  logic                    clr_ovf,
  output logic                    irq
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic       REP_EN = (REPEAT_DELAY != 24'd0);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic [NKEYS-1:0] keys_q, rptd_q, rptd_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             rep_active_q, rep_active_d;
  logic             rep_rate_q, rep_rate_d;
  logic [23:0]      rep_cnt_q, rep_cnt_d;
  logic [IDXW-1:0]  rep_key_q, rep_key_d;
  logic [IDXW+1:0]  mem [DEPTH];

  logic [NKEYS-1:0] dirty;
  logic             any_dirty;
  logic [IDXW-1:0]  idx;
  logic             pop, room, due;
  logic             edge_push, rep_push, rep_drop, push;
  logic [IDXW+1:0]  push_data;

  always_comb begin
    dirty     = keys_q ^ rptd_q;
    any_dirty = |dirty;
    idx       = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (dirty[i]) idx = IDXW'(i);
    end
  end

  // A pop in the same cycle frees the slot a push needs.
  always_comb begin
    pop       = rd && (count_q != '0);
    room      = (count_q != FULL) || pop;
    due       = rep_active_q &&
                (rep_rate_q ? (rep_cnt_q == REPEAT_RATE - 24'd1)
                            : (rep_cnt_q == REPEAT_DELAY - 24'd1));
    edge_push = any_dirty && room;
    rep_push  = due && !any_dirty && room;
    rep_drop  = due && !any_dirty && !room;
    push      = edge_push || rep_push;
    push_data = edge_push ? {1'b0, keys_q[idx], idx}
                          : {2'b10, rep_key_q};
  end

  always_comb begin
    rptd_d       = rptd_q;
    rep_active_d = rep_active_q;
    rep_rate_d   = rep_rate_q;
    rep_cnt_d    = rep_cnt_q;
    rep_key_d    = rep_key_q;
    if (rep_active_q) begin
      if (due) begin
        rep_cnt_d  = '0;
        rep_rate_d = 1'b1;
      end else begin
        rep_cnt_d  = rep_cnt_q + 24'd1;
      end
    end
    if (edge_push) begin
      rptd_d[idx] = keys_q[idx];
      if (REP_EN && keys_q[idx]) begin
        rep_key_d    = idx;
        rep_active_d = 1'b1;
        rep_cnt_d    = '0;
        rep_rate_d   = 1'b0;
      end else if (idx == rep_key_q) begin
        rep_active_d = 1'b0;
      end
    end
  end

  always_comb begin
    ovf_d    = rep_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q       <= '0;
      rptd_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      rep_active_q <= 1'b0;
      rep_rate_q   <= 1'b0;
      rep_cnt_q    <= '0;
      rep_key_q    <= '0;
    end else begin
      keys_q       <= keys;
      rptd_q       <= rptd_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      rep_active_q <= rep_active_d;
      rep_rate_q   <= rep_rate_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_key_q    <= rep_key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign irq       = evt_valid | ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: two configurations, scoreboarded events.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys_a = 8'h04;
  logic [7:0] keys_b = 8'h00;
  logic       rd_a = 1'b0, rd_b = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0;

  logic       evt_valid_a, evt_valid_b;
  logic [4:0] evt_data_a, evt_data_b;
  logic [3:0] count_a;
  logic [2:0] count_b;
  logic       ovf_a, ovf_b, irq_a, irq_b;

  int n_checks = 0;
  int n_err    = 0;
  logic [4:0] qa[$];
  logic [4:0] qb[$];

  always #5 clk = ~clk;

  key_event_queue #(
    .NKEYS(8), .IDXW(3), .DEPTH(8),
    .REPEAT_DELAY(24'd10), .REPEAT_RATE(24'd4)
  ) u_a (
    .clk(clk), .rst(rst), .keys(keys_a), .rd(rd_a),
    .evt_valid(evt_valid_a), .evt_data(evt_data_a),
    .count(count_a), .ovf(ovf_a), .clr_ovf(clr_a), .irq(irq_a)
  );

  key_event_queue #(
    .NKEYS(8), .IDXW(3), .DEPTH(4),
    .REPEAT_DELAY(24'd0), .REPEAT_RATE(24'd4)
  ) u_b (
    .clk(clk), .rst(rst), .keys(keys_b), .rd(rd_b),
    .evt_valid(evt_valid_b), .evt_data(evt_data_b),
    .count(count_b), .ovf(ovf_b), .clr_ovf(clr_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain_a(input int n);
    int w;
    for (int j = 0; j < n; j++) begin
      w = 0;
      while (!evt_valid_a && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("valid_a", evt_valid_a, 1'b1);
      chk("data_a", evt_data_a, qa.pop_front());
      rd_a = 1'b1;
      @(negedge clk);
      rd_a = 1'b0;
    end
  endtask

  task automatic drain_b(input int n);
    int w;
    for (int j = 0; j < n; j++) begin
      w = 0;
      while (!evt_valid_b && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk("valid_b", evt_valid_b, 1'b1);
      chk("data_b", evt_data_b, qb.pop_front());
      rd_b = 1'b1;
      @(negedge clk);
      rd_b = 1'b0;
    end
  endtask

  initial begin
    int c;
    int o;

    // reset state, key 2 already held
    tick(3);
    chk("rst_valid", evt_valid_a, 1'b0);
    chk("rst_count", count_a, 0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_irq", irq_a, 1'b0);
    chk("rst_data", evt_data_a, 0);
    rst = 1'b0;
    qa.push_back(5'b01_010);
    tick(1);
    chk("lat_count", count_a, 0);
    tick(1);
    chk("first_count", count_a, 1);
    chk("first_irq", irq_a, 1'b1);
    drain_a(1);
    chk("pop_valid", evt_valid_a, 1'b0);
    chk("pop_irq", irq_a, 1'b0);
    keys_a = 8'h00;
    qa.push_back(5'b00_010);
    drain_a(1);

    // two keys change together: lowest index first
    keys_a = 8'h81;
    qa.push_back(5'b01_000);
    qa.push_back(5'b01_111);
    tick(3);
    chk("two_press", count_a, 2);
    keys_a = 8'h00;
    qa.push_back(5'b00_000);
    qa.push_back(5'b00_111);
    tick(3);
    chk("two_rel", count_a, 4);
    tick(15);
    chk("no_rep", count_a, 4);
    drain_a(4);
    chk("two_empty", evt_valid_a, 1'b0);

    // auto-repeat on key 5: press t=2, repeats 12..28, release 32
    keys_a = 8'h20;
    qa.push_back(5'b01_101);
    repeat (5) qa.push_back(5'b10_101);
    qa.push_back(5'b00_101);
    for (int k = 1; k <= 45; k++) begin
      tick(1);
      c = (k >= 2) ? 1 : 0;
      for (int r = 12; r <= 28; r += 4) if (k >= r) c++;
      if (k >= 32) c++;
      chk("rep_count", count_a, c);
      if (k == 30) keys_a = 8'h00;
    end
    drain_a(7);

    // fill with repeats of key 1, then overflow and clear
    keys_a = 8'h02;
    qa.push_back(5'b01_001);
    repeat (7) qa.push_back(5'b10_001);
    qa.push_back(5'b00_001);
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      c = (k >= 2) ? 1 : 0;
      for (int r = 12; r <= 36; r += 4) if (k >= r) c++;
      o = (k >= 40 && k < 46) ? 1 : 0;
      chk("full_count", count_a, c);
      chk("ovf", ovf_a, o[0]);
      if (k == 41) chk("ovf_irq", irq_a, 1'b1);
      if (k == 43) clr_a = 1'b1;
      if (k == 44) clr_a = 1'b0;
      if (k == 45) clr_a = 1'b1;
      if (k == 46) begin
        clr_a  = 1'b0;
        keys_a = 8'h00;
      end
    end
    drain_a(9);
    tick(1);
    chk("ovf_empty", count_a, 0);

    // no repeat: 6 edges into 4 slots, plus a key-3 blip
    keys_b = 8'h07;
    qb.push_back(5'b01_000);
    qb.push_back(5'b01_001);
    qb.push_back(5'b01_010);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      c = 0;
      if (k >= 2) c++;
      if (k >= 3) c++;
      if (k >= 4) c++;
      if (k >= 6) c++;
      chk("b_count", count_b, c);
      chk("b_ovf", ovf_b, 1'b0);
      if (k == 4) begin
        keys_b = 8'h00;
        qb.push_back(5'b00_000);
        qb.push_back(5'b00_001);
        qb.push_back(5'b00_010);
      end
      if (k == 10) keys_b = 8'h08;
      if (k == 11) keys_b = 8'h00;
    end
    drain_b(6);
    tick(5);
    chk("b_empty_cnt", count_b, 0);
    chk("b_empty_vld", evt_valid_b, 1'b0);
    rd_b = 1'b1;
    tick(1);
    rd_b = 1'b0;
    chk("b_rd_empty", count_b, 0);

    // asynchronous reset with events queued
    keys_a = 8'h07;
    tick(4);
    chk("pre_rst", count_a, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", count_a, 0);
    chk("arst_valid", evt_valid_a, 1'b0);
    chk("arst_irq", irq_a, 1'b0);
    keys_a = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("post_rst", count_a, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
